// File: rtl/mem_bus_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_pkg
// Shared definitions for the memory bus controller: default bus widths,
// default watchdog limit, RAM read/write encoding and the controller state enum.
// -----------------------------------------------------------------------------
package mem_bus_pkg;

    localparam int MBC_ADDR_W_DEF  = 8;
    localparam int MBC_DATA_W_DEF  = 8;
    localparam int MBC_TIMEOUT_DEF = 15;

    // Encoding of the rnw line toward the RAM
    localparam logic RNW_READ  = 1'b1;
    localparam logic RNW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ASSERT  = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_RELEASE = 3'd3,
        ST_WAIT_LO = 3'd4,
        ST_DONE    = 3'd5
    } mbc_state_t;

endpackage

// File: rtl/mbc_watchdog.sv
// -----------------------------------------------------------------------------
// mbc_watchdog
// Saturating cycle counter that bounds how long the controller waits for the
// RAM handshake.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_clr      synchronous clear (wins over i_inc)
//   i_inc      count one cycle
//   o_expired  high in the cycle whose increment brings the count to TIMEOUT,
//              so the owner can leave its wait state on exactly the TIMEOUT-th
//              waiting cycle
// -----------------------------------------------------------------------------
module mbc_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT    = CW'(TIMEOUT);
    localparam logic [CW-1:0] LIMIT_M1 = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != LIMIT)) begin
            // Saturate at TIMEOUT; the counter never wraps
            r_count <= r_count + 1'b1;
        end
    end

    // Compare the pre-increment value against TIMEOUT-1 so the check cannot
    // overflow when TIMEOUT equals the counter's maximum value.
    assign o_expired = i_inc && (r_count >= LIMIT_M1);

endmodule

// File: rtl/mem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// mem_bus_ctrl
// Memory bus controller between the CPU control unit and a 256x8 RAM. Accepts
// one read/write request at a time, drives MAR/enable/rnw/bus toward the RAM,
// follows the MFC rise/fall handshake and returns a one-cycle done pulse with
// an error flag when the watchdog aborted the access.
//
// Ports:
//   CLK, RST_N          clock (rising edge), async active-low reset
//   req, req_rnw,       request strobe (sampled in IDLE only), 1=read 0=write,
//   req_addr, req_wdata   access address, write data
//   busy                high in every state except IDLE (decoded from state)
//   done, err           one-cycle completion pulse; err=1 marks a watchdog abort
//   rdata               last successfully read byte
//   MAR, enable, rnw,   address, access enable, direction and write data to RAM
//   bus
//   MBR, MFC            read data and function-complete from RAM
//   o_dbg_state         current FSM state, for observation only
//
// Handshake: a request is taken when req=1 is sampled in IDLE; anything
// presented while busy=1 is dropped. enable rises two edges after the accepting
// edge, falls one edge after MFC is seen high, and done follows once MFC is
// seen low again (or the watchdog gives up on either phase).
// -----------------------------------------------------------------------------
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W  = MBC_ADDR_W_DEF,
    parameter int DATA_W  = MBC_DATA_W_DEF,
    parameter int TIMEOUT = MBC_TIMEOUT_DEF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              req,
    input  logic              req_rnw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] MAR,
    output logic              enable,
    output logic              rnw,
    output logic [DATA_W-1:0] bus,
    input  logic [DATA_W-1:0] MBR,
    input  logic              MFC,
    output mbc_state_t        o_dbg_state
);

    // Reset: asserts asynchronously, releases on a clock edge
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    mbc_state_t        r_state;
    mbc_state_t        w_state_nxt;
    logic              w_wd_clr;
    logic              w_wd_inc;
    logic              w_wd_expired;

    logic [ADDR_W-1:0] r_mar;
    logic              r_rnw;
    logic [DATA_W-1:0] r_bus;
    logic              r_enable;
    logic              r_done;
    logic              r_err;
    logic              r_abort;
    logic [DATA_W-1:0] r_rd_hold;
    logic [DATA_W-1:0] r_rdata;

    mbc_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk     (CLK),
        .i_rst_n   (w_rst_n),
        .i_clr     (w_wd_clr),
        .i_inc     (w_wd_inc),
        .o_expired (w_wd_expired)
    );

    // State register
    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and watchdog control
    always_comb begin
        w_state_nxt = r_state;
        w_wd_clr    = 1'b0;
        w_wd_inc    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_wd_clr = 1'b1;
                if (req) begin
                    w_state_nxt = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                w_state_nxt = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                w_wd_inc = 1'b1;
                // MFC wins over a coincident expiry
                if (MFC || w_wd_expired) begin
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_wd_clr    = 1'b1;
                w_state_nxt = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                w_wd_inc = 1'b1;
                if (!MFC || w_wd_expired) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered outputs and datapath. Outputs are registered decodes of the
    // state, so each lands one edge after the state that calls for it: the
    // ASSERT cycle lets MAR/rnw/bus settle before enable goes high.
    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_mar     <= '0;
            r_rnw     <= RNW_READ;
            r_bus     <= '0;
            r_enable  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_abort   <= 1'b0;
            r_rd_hold <= '0;
            r_rdata   <= '0;
        end else begin
            r_enable <= (r_state == ST_WAIT_HI);
            r_done   <= (r_state == ST_DONE);
            r_err    <= (r_state == ST_DONE) && r_abort;

            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_mar   <= req_addr;
                        r_rnw   <= req_rnw;
                        r_bus   <= req_wdata;
                        r_abort <= 1'b0;
                    end
                end
                ST_WAIT_HI: begin
                    if (MFC) begin
                        if (r_rnw == RNW_READ) begin
                            r_rd_hold <= MBR;
                        end
                    end else if (w_wd_expired) begin
                        r_abort <= 1'b1;
                    end
                end
                ST_WAIT_LO: begin
                    if (MFC && w_wd_expired) begin
                        r_abort <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // Read data is committed only once the whole handshake
                    // finished cleanly, so an aborted read never touches rdata.
                    if (!r_abort && (r_rnw == RNW_READ)) begin
                        r_rdata <= r_rd_hold;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign err         = r_err;
    assign rdata       = r_rdata;
    assign MAR         = r_mar;
    assign enable      = r_enable;
    assign rnw         = r_rnw;
    assign bus         = r_bus;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_ctrl
// Bench for mem_bus_ctrl with a behavioural RAM (programmable MFC behaviour),
// a reference model of the access outcome and a done-driven scoreboard.
// -----------------------------------------------------------------------------
module tb_mem_bus_ctrl;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 4;

    // ---------------- clock / reset ----------------
    logic          CLK   = 1'b0;
    logic          RST_N = 1'b0;

    always #5 CLK = ~CLK;

    logic          req       = 1'b0;
    logic          req_rnw   = 1'b1;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] rdata;
    logic [AW-1:0] MAR;
    logic          enable;
    logic          rnw;
    logic [DW-1:0] bus;
    logic [DW-1:0] MBR;
    logic          MFC;
    mem_bus_pkg::mbc_state_t dbg_state;

    mem_bus_ctrl #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .req         (req),
        .req_rnw     (req_rnw),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .rdata       (rdata),
        .MAR         (MAR),
        .enable      (enable),
        .rnw         (rnw),
        .bus         (bus),
        .MBR         (MBR),
        .MFC         (MFC),
        .o_dbg_state (dbg_state)
    );

    // ---------------- behavioural RAM ----------------
    // hi_stuck: MFC never rises. lo_stuck: MFC never falls.
    // hi_lat:   extra cycles of enable before MFC rises.
    logic [DW-1:0] ram_mem [256];
    bit            hi_stuck = 1'b0;
    bit            lo_stuck = 1'b0;
    int            hi_lat   = 0;
    int            hi_cnt   = 0;

    always @(posedge CLK) begin
        if (enable && !MFC) begin
            if (!hi_stuck) begin
                if (hi_cnt >= hi_lat) begin
                    MFC    <= 1'b1;
                    MBR    <= ram_mem[MAR];
                    if (!rnw) ram_mem[MAR] <= bus;
                    hi_cnt <= 0;
                end else begin
                    hi_cnt <= hi_cnt + 1;
                end
            end
        end else if (!enable) begin
            hi_cnt <= 0;
            if (MFC && !lo_stuck) MFC <= 1'b0;
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] ref_rdata = '0;
    logic [DW:0]   exp_q[$];          // {err, rdata}
    logic [DW:0]   mon_exp;

    int n_cmp       = 0;
    int n_bad       = 0;
    int done_cnt    = 0;
    int start_done  = 0;
    int en_run      = 0;
    int last_en_len = 0;

    bit            watch_en   = 1'b0;
    logic [AW-1:0] watch_addr = '0;
    logic          watch_rnw  = 1'b1;
    logic [DW-1:0] watch_bus  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every done pulse against the queue, tracks enable
    // pulse length and checks that the access lines stay put while busy.
    always @(negedge CLK) begin
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 err=%0b rdata=0x%0h, expected no done (t=%0t)",
                         err, rdata, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("done_err", {31'd0, err}, {31'd0, mon_exp[DW]});
                check("done_rdata", {24'd0, rdata}, {24'd0, mon_exp[DW-1:0]});
            end
        end
        if (enable) begin
            en_run++;
        end else if (en_run != 0) begin
            last_en_len = en_run;
            en_run      = 0;
        end
        if (watch_en && busy) begin
            check("hold_mar", {24'd0, MAR}, {24'd0, watch_addr});
            check("hold_rnw", {31'd0, rnw}, {31'd0, watch_rnw});
            if (!watch_rnw) check("hold_bus", {24'd0, bus}, {24'd0, watch_bus});
        end
    end

    // ---------------- driver tasks ----------------
    // Outcome rules: a missing MFC rise aborts and leaves RAM and rdata alone;
    // a missing MFC fall aborts after the RAM already performed the access;
    // otherwise the access succeeds and a read returns the stored byte.
    task automatic start_req(input logic r, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input bit push);
        logic e;
        if (push) begin
            if (hi_stuck) begin
                e = 1'b1;
            end else begin
                if (!r) ref_mem[a] = d;
                e = lo_stuck;
                if (!e && r) ref_rdata = ref_mem[a];
            end
            exp_q.push_back({e, ref_rdata});
        end
        start_done = done_cnt;
        req_rnw    = r;
        req_addr   = a;
        req_wdata  = d;
        req        = 1'b1;
        @(negedge CLK);
        req        = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int cyc;
        cyc = 0;
        while (done_cnt == start_done && cyc < 100) begin
            @(negedge CLK);
            cyc++;
        end
        n_cmp++;
        if (done_cnt == start_done) begin
            n_bad++;
            $display("FAIL %s_done: got no done in 100 cycles, expected a done pulse", name);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
    endtask

    task automatic settle();
        hi_stuck = 1'b0;
        lo_stuck = 1'b0;
        hi_lat   = 0;
        watch_en = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        logic          r;
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 8'($urandom);
            ref_mem[i] = ram_mem[i];
        end
        ram_mem[0] = 8'h48; ref_mem[0] = 8'h48;
        ram_mem[8] = 8'h01; ref_mem[8] = 8'h01;

        // Reset with MFC held high
        MFC      = 1'b1;
        MBR      = '0;
        lo_stuck = 1'b1;
        RST_N    = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_enable", {31'd0, enable}, 32'd0);
        check("rst_rnw",    {31'd0, rnw},    32'd1);
        check("rst_mar",    {24'd0, MAR},    32'd0);
        check("rst_bus",    {24'd0, bus},    32'd0);
        check("rst_rdata",  {24'd0, rdata},  32'd0);
        check("rst_done",   {31'd0, done},   32'd0);
        check("rst_err",    {31'd0, err},    32'd0);
        check("rst_busy",   {31'd0, busy},   32'd0);
        MFC      = 1'b0;
        lo_stuck = 1'b0;
        RST_N    = 1'b1;
        repeat (4) @(negedge CLK);

        // Read 0x08 with enable timing
        watch_addr = 8'h08; watch_rnw = 1'b1; watch_en = 1'b1;
        start_req(1'b1, 8'h08, 8'h00, 1'b1);
        check("rd_enable_n0", {31'd0, enable}, 32'd0);
        check("rd_busy",      {31'd0, busy},   32'd1);
        @(negedge CLK);
        check("rd_enable_n1", {31'd0, enable}, 32'd0);
        @(negedge CLK);
        check("rd_enable_n2", {31'd0, enable}, 32'd1);
        check("rd_mar_n2",    {24'd0, MAR},    32'h08);
        wait_done("rd08");
        settle();

        // Write 0x5A to 0x20, read it back
        watch_addr = 8'h20; watch_rnw = 1'b0; watch_bus = 8'h5A; watch_en = 1'b1;
        start_req(1'b0, 8'h20, 8'h5A, 1'b1);
        wait_done("wr20");
        settle();
        start_req(1'b1, 8'h20, 8'h00, 1'b1);
        wait_done("rd20");
        settle();

        // Watchdog abort on a read whose MFC never rises
        hi_stuck = 1'b1;
        start_req(1'b1, 8'h40, 8'h00, 1'b1);
        wait_done("timeout");
        check("timeout_enable_cycles", last_en_len, TO);
        settle();

        // Request while busy is dropped
        base = done_cnt;
        watch_addr = 8'h08; watch_rnw = 1'b1; watch_en = 1'b1;
        start_req(1'b1, 8'h08, 8'h00, 1'b1);
        @(negedge CLK);
        req_addr = 8'h30;
        req      = 1'b1;
        @(negedge CLK);
        req      = 1'b0;
        wait_done("busy_ignore");
        repeat (10) @(negedge CLK);
        check("busy_ignore_done_count", done_cnt - base, 32'd1);
        settle();

        // Reset in the middle of WAIT_HI
        hi_stuck = 1'b1;
        start_req(1'b1, 8'h00, 8'h00, 1'b0);
        repeat (3) @(negedge CLK);
        check("mr_enable_before", {31'd0, enable}, 32'd1);
        base = done_cnt;
        #2;
        RST_N = 1'b0;
        #1;
        check("mr_enable_drop", {31'd0, enable}, 32'd0);
        check("mr_busy_drop",   {31'd0, busy},   32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N    = 1'b1;
        hi_stuck = 1'b0;
        ref_rdata = '0;
        repeat (5) @(negedge CLK);
        check("mr_no_done", done_cnt - base, 32'd0);
        start_req(1'b1, 8'h00, 8'h00, 1'b1);
        wait_done("mr_rd00");
        settle();

        // Randomized accesses
        for (int n = 0; n < 40; n++) begin
            r        = 1'($urandom_range(0, 1));
            a        = 8'($urandom);
            d        = 8'($urandom);
            hi_stuck = ($urandom_range(0, 7) == 0);
            lo_stuck = !hi_stuck && ($urandom_range(0, 7) == 0);
            hi_lat   = $urandom_range(0, 1);
            start_req(r, a, d, 1'b1);
            wait_done("rand");
            settle();
        end

        @(negedge CLK);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no end of test, expected finish before 500000");
        $fatal(1, "simulation time limit");
    end

endmodule
